wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 164 ++++++++++++++++
 tb/tb_wb_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Arbitrates the register-file write port between the in-order pipeline
// result (A, never back-pressured) and a long-latency unit (B) whose results
// are parked in a 2-entry in-order FIFO until the write port is free.
// A always wins the port. A queued B result that waits too long raises
// stall_req so that the pipeline controller opens a slot for it.
// A younger A write to the same register kills the stale queued B results
// (write-after-write), so a late B write never overwrites newer A data.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   a_valid    pipeline result valid (A)
//   a_waddr    A destination register
//   a_wdata    A result data
//   b_valid    long-latency result valid (B)
//   b_ready    arbiter can accept a B result this cycle
//   b_waddr    B destination register
//   b_wdata    B result data
//   we         registered regfile write enable
//   waddr      registered regfile write address
//   wdata      registered regfile write data
//   stall_req  registered request to hold a_valid low
//   q_cnt      number of queued B results (0..2)
// -----------------------------------------------------------------------------
module wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  input  logic [4:0]  a_waddr,
  input  logic [31:0] a_wdata,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_waddr,
  input  logic [31:0] b_wdata,
  output logic        we,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic        stall_req,
  output logic [1:0]  q_cnt
);

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  // FIFO storage: entry 0 is always the head, valid entries are packed low.
  logic [4:0]  addr_q [2];
  logic [4:0]  addr_d [2];
  logic [31:0] data_q [2];
  logic [31:0] data_d [2];
  logic [1:0]  cnt_q, cnt_d;

  logic [3:0]  starve_q, starve_d;
  logic        stall_q, stall_d;
  logic        we_q, we_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        enq;
  logic        deq;
  logic [1:0]  keep;

  // Ready comes from the registered count only; a dequeue in the same cycle
  // does not open a slot for an incoming B result.
  assign b_ready = (cnt_q < 2'd2);
  assign enq     = b_valid && b_ready;
  assign deq     = !a_valid && (cnt_q != 2'd0);

  // Next-state logic: pick the write source, drop killed or dequeued
  // entries, compact the survivors towards the head, then append B.
  // The B result accepted this cycle is appended after the kill check,
  // since it is younger than the A write.
  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    cnt_d    = 2'd0;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    starve_d = starve_q;
    stall_d  = 1'b0;
    keep     = {cnt_q > 2'd1, cnt_q > 2'd0};

    if (a_valid) begin
      if (a_waddr != 5'd0) begin
        we_d    = 1'b1;
        waddr_d = a_waddr;
        wdata_d = a_wdata;
      end
      if (addr_q[0] == a_waddr) keep[0] = 1'b0;
      if (addr_q[1] == a_waddr) keep[1] = 1'b0;
    end else if (deq) begin
      keep[0] = 1'b0;
      if (addr_q[0] != 5'd0) begin
        we_d    = 1'b1;
        waddr_d = addr_q[0];
        wdata_d = data_q[0];
      end
    end

    case (keep)
      2'b11: cnt_d = 2'd2;
      2'b01: cnt_d = 2'd1;
      2'b10: begin
        addr_d[0] = addr_q[1];
        data_d[0] = data_q[1];
        cnt_d     = 2'd1;
      end
      default: cnt_d = 2'd0;
    endcase

    if (enq) begin
      if (cnt_d == 2'd0) begin
        addr_d[0] = b_waddr;
        data_d[0] = b_wdata;
      end else begin
        addr_d[1] = b_waddr;
        data_d[1] = b_wdata;
      end
      cnt_d = cnt_d + 2'd1;
    end

    // The counter tracks how long the current head has been blocked; it
    // saturates so stall_req stays high until the head finally drains.
    if (deq || (cnt_d == 2'd0)) begin
      starve_d = 4'd0;
    end else if ((cnt_q != 2'd0) && (starve_q < Limit)) begin
      starve_d = starve_q + 4'd1;
    end
    stall_d = (starve_d == Limit);
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '{default: '0};
      data_q   <= '{default: '0};
      cnt_q    <= 2'd0;
      starve_q <= 4'd0;
      stall_q  <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= 5'd0;
      wdata_q  <= 32'd0;
    end else begin
      addr_q   <= addr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign we        = we_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign stall_req = stall_q;
  assign q_cnt     = cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
// Self-checking bench for wb_arbiter. A queue-based reference model tracks
// the pending B results; directed scenarios are followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_valid = 1'b0;
  logic [4:0]  a_waddr = '0;
  logic [31:0] a_wdata = '0;
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [4:0]  b_waddr = '0;
  logic [31:0] b_wdata = '0;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        stall_req;
  logic [1:0]  q_cnt;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  entry_t mq[$];
  int     waitCnt = 0;
  int     compared = 0;
  int     mismatched = 0;

  wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_waddr   (a_waddr),
    .a_wdata   (a_wdata),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_waddr   (b_waddr),
    .b_wdata   (b_wdata),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .stall_req (stall_req),
    .q_cnt     (q_cnt)
  );

  always #5 clk = ~clk;

  // One comparison with an immediate assertion.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs (called just after a rising edge), predicts
  // the result from the model and checks the registered outputs afterwards.
  task automatic applyStimulus(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                               input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    int          sizeBefore;
    bit          accept;
    bit          popped;
    bit          expWe;
    logic [4:0]  expAddr;
    logic [31:0] expData;
    entry_t      e;
    a_valid = av; a_waddr = aa; a_wdata = ad;
    b_valid = bv; b_waddr = ba; b_wdata = bd;
    sizeBefore = mq.size();
    accept = bv && (sizeBefore < 2);
    checkOutput("b_ready", {31'b0, b_ready}, {31'b0, sizeBefore < 2});
    expWe = 1'b0; popped = 1'b0; expAddr = '0; expData = '0;
    if (av) begin
      if (aa != 5'd0) begin
        expWe = 1'b1; expAddr = aa; expData = ad;
      end
      for (int i = mq.size() - 1; i >= 0; i--)
        if (mq[i].addr == aa) mq.delete(i);
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      popped = 1'b1;
      if (e.addr != 5'd0) begin
        expWe = 1'b1; expAddr = e.addr; expData = e.data;
      end
    end
    if (accept) begin
      e.addr = ba; e.data = bd;
      mq.push_back(e);
    end
    if (popped || mq.size() == 0) waitCnt = 0;
    else if (sizeBefore > 0 && waitCnt < int'(LIMIT)) waitCnt++;
    @(posedge clk);
    #1;
    checkOutput("we", {31'b0, we}, {31'b0, expWe});
    if (expWe) begin
      checkOutput("waddr", {27'b0, waddr}, {27'b0, expAddr});
      checkOutput("wdata", wdata, expData);
    end
    checkOutput("stall_req", {31'b0, stall_req}, {31'b0, waitCnt == int'(LIMIT)});
    checkOutput("q_cnt", {30'b0, q_cnt}, 32'(mq.size()));
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // Asynchronous reset pulse in the middle of a cycle; outputs must clear
  // before the next clock edge.
  task automatic doReset();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_we", {31'b0, we}, 32'd0);
    checkOutput("rst_waddr", {27'b0, waddr}, 32'd0);
    checkOutput("rst_wdata", wdata, 32'd0);
    checkOutput("rst_stall", {31'b0, stall_req}, 32'd0);
    checkOutput("rst_q_cnt", {30'b0, q_cnt}, 32'd0);
    checkOutput("rst_b_ready", {31'b0, b_ready}, 32'd1);
    mq.delete();
    waitCnt = 0;
    a_valid = 1'b0; b_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int aProb;
    $display("[TB] start");
    @(posedge clk);
    #1;
    checkOutput("init_we", {31'b0, we}, 32'd0);
    checkOutput("init_q_cnt", {30'b0, q_cnt}, 32'd0);
    checkOutput("init_stall", {31'b0, stall_req}, 32'd0);
    rst_n = 1'b1;
    idle();

    // Single A write, then an idle cycle.
    applyStimulus(1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0, 32'd0);
    idle();

    // Two B results queued behind A writes, then drained in order.
    applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd5, 32'hA);
    applyStimulus(1'b1, 5'd2, 32'h22, 1'b1, 5'd6, 32'hB);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'hC);
    idle();
    idle();

    // Starvation: head blocked by continuous A traffic.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 5'(10 + i), 32'(i), 1'b0, 5'd0, 32'd0);
    idle();
    idle();

    // WAW kill of a queued entry.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h1);
    applyStimulus(1'b1, 5'd9, 32'h2, 1'b0, 5'd0, 32'd0);
    idle();
    idle();

    // WAW kill does not hit a B result enqueued in the same cycle.
    applyStimulus(1'b1, 5'd12, 32'h3, 1'b1, 5'd12, 32'h4);
    idle();

    // A write to register 0 consumes the port; the head waits a cycle.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h44);
    applyStimulus(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0);
    idle();

    // B result with address 0 is dequeued without a write.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h66);
    idle();

    // Reset with a full FIFO and stall_req asserted.
    applyStimulus(1'b1, 5'd20, 32'h20, 1'b1, 5'd21, 32'h21);
    applyStimulus(1'b1, 5'd22, 32'h22, 1'b1, 5'd23, 32'h23);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 5'(24 + i), 32'(i), 1'b0, 5'd0, 32'd0);
    checkOutput("pre_rst_stall", {31'b0, stall_req}, 32'd1);
    doReset();
    idle();
    idle();

    // Randomized traffic with phases of heavy A load to provoke stalls.
    for (int n = 0; n < 400; n++) begin
      aProb = ((n / 50) % 2 == 1) ? 92 : 45;
      if (n == 260) doReset();
      applyStimulus($urandom_range(0, 99) < aProb, 5'($urandom_range(0, 7)), $urandom,
                    $urandom_range(0, 99) < 55, 5'($urandom_range(0, 7)), $urandom);
    end
    idle();
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
